// File: rtl/addsub_mod_pkg.sv
// addsub_mod_pkg: op encoding and default parameters for the modular add/sub pipeline
package addsub_mod_pkg;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_NEG = 2'b10, OP_DBL = 2'b11} op_e;
  localparam int DEF_WIDTH = 32;
  localparam logic [31:0] DEF_MODULUS = 32'hFFFF_FFFB;
  localparam int LATENCY = 2;
endpackage

// File: rtl/mod_correct.sv
// mod_correct: folds a raw (WIDTH+1)-bit sum/difference back into [0, MODULUS)
module mod_correct
  import addsub_mod_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] MODULUS = WIDTH'(DEF_MODULUS)
) (
  input  logic [WIDTH:0]   raw_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] res_o
);
  logic [WIDTH:0]   dn;
  logic [WIDTH-1:0] up;
  // dn[WIDTH] is the borrow of raw - P for any in-range add/dbl result
  assign dn = raw_i - {1'b0, MODULUS};
  assign up = raw_i[WIDTH-1:0] + MODULUS;
  assign res_o = sub_i ? (raw_i[WIDTH] ? up : raw_i[WIDTH-1:0])
                       : (dn[WIDTH] ? raw_i[WIDTH-1:0] : dn[WIDTH-1:0]);
endmodule

// File: rtl/addsub_mod_pipe.sv
// addsub_mod_pipe: two-stage valid/ready modular add/sub/neg/dbl pipeline
module addsub_mod_pipe
  import addsub_mod_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] MODULUS = WIDTH'(DEF_MODULUS),
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  op_e              op;
  logic [WIDTH-1:0] x, y;
  logic             sub_d, sub_q;
  logic [WIDTH:0]   raw_d, raw_q;
  logic [TAG_W-1:0] tag1_q, tag2_q;
  logic [WIDTH-1:0] corr, res_q;
  logic             s1_v_d, s1_v_q, s2_v_d, s2_v_q;
  logic             in_fire, s1_adv;
  always_comb begin
    op    = op_e'(in_op);
    x     = (op == OP_NEG) ? '0 : in_a;
    y     = (op == OP_DBL) ? in_a : in_b;
    sub_d = (op == OP_SUB) || (op == OP_NEG);
    raw_d = sub_d ? {1'b0, x} - {1'b0, y} : {1'b0, x} + {1'b0, y};
  end
  // in_ready depends on out_ready and state only, never on in_valid
  assign s1_adv   = s1_v_q && (!s2_v_q || out_ready);
  assign in_ready = !s1_v_q || s1_adv;
  assign in_fire  = in_valid && in_ready;
  assign s1_v_d   = in_fire ? 1'b1 : (s1_adv ? 1'b0 : s1_v_q);
  assign s2_v_d   = s1_adv ? 1'b1 : (out_ready ? 1'b0 : s2_v_q);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
    end
  end
  always_ff @(posedge clk) begin
    if (in_fire) begin
      raw_q  <= raw_d;
      sub_q  <= sub_d;
      tag1_q <= in_tag;
    end
    if (s1_adv) begin
      res_q  <= corr;
      tag2_q <= tag1_q;
    end
  end
  mod_correct #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_corr (
    .raw_i(raw_q),
    .sub_i(sub_q),
    .res_o(corr)
  );
  assign out_valid = s2_v_q;
  assign out_res   = s2_v_q ? res_q : '0;
  assign out_tag   = s2_v_q ? tag2_q : '0;
  assign busy      = s1_v_q || s2_v_q;
endmodule

// File: tb/tb_addsub_mod_pipe.sv
// tb_addsub_mod_pipe: vector table, scoreboard and handshake corner cases for addsub_mod_pipe
module tb_addsub_mod_pipe;
  localparam logic [31:0] DP = 32'hFFFF_FFFB;
  logic clk, rst;
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0] in_op;
  logic [7:0] in_a, in_b, in_tag, out_res, out_tag;
  logic d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_busy;
  logic [1:0] d_in_op;
  logic [31:0] d_in_a, d_in_b, d_out_res;
  logic [7:0] d_in_tag, d_out_tag;
  typedef struct {logic [7:0] res; logic [7:0] tag;} exp_t;
  typedef struct {logic [1:0] op; logic [7:0] a; logic [7:0] b; logic [7:0] exp;} vec_t;
  exp_t exp_q[$];
  vec_t vt[12];
  int n_chk, n_err, n_out;
  logic stall_prev;
  logic [7:0] prev_res, prev_tag;

  addsub_mod_pipe #(.WIDTH(8), .MODULUS(8'd251), .TAG_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_tag(out_tag), .busy(busy)
  );
  addsub_mod_pipe dut_def (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_op(d_in_op),
    .in_a(d_in_a), .in_b(d_in_b), .in_tag(d_in_tag), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_res(d_out_res), .out_tag(d_out_tag), .busy(d_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int p, ai, bi, r;
    p = 251; ai = int'(a); bi = int'(b);
    case (op)
      2'd0: r = (ai + bi) % p;
      2'd1: r = (ai + p - bi) % p;
      2'd2: r = (p - bi) % p;
      default: r = (2 * ai) % p;
    endcase
    return 8'(r);
  endfunction

  task automatic drive_rand(input logic [7:0] t);
    in_valid = 1'b1;
    in_op = 2'($urandom_range(0, 3));
    in_a = 8'($urandom_range(0, 250));
    in_b = 8'($urandom_range(0, 250));
    in_tag = t;
  endtask

  always @(negedge clk) begin
    if (rst) stall_prev = 1'b0;
    else begin
      if (in_valid && in_ready) exp_q.push_back('{model(in_op, in_a, in_b), in_tag});
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_res", 32'(out_res), 32'(prev_res));
        chk("stall_tag", 32'(out_tag), 32'(prev_tag));
      end
      if (!in_ready) chk("rdy_low_only_full", 32'(out_valid && !out_ready), 32'd1);
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) chk("unexpected_out", 32'(out_tag), 32'hFFFF_FFFF);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_res", 32'(out_res), 32'(e.res));
          chk("sb_tag", 32'(out_tag), 32'(e.tag));
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_res = out_res;
      prev_tag = out_tag;
    end
  end

  initial begin
    logic fired;
    logic [7:0] tag_n;
    int n0;
    n_chk = 0; n_err = 0; n_out = 0; stall_prev = 1'b0;
    vt[0]  = '{2'd0, 8'd250, 8'd250, 8'd249};
    vt[1]  = '{2'd1, 8'd0,   8'd250, 8'd1};
    vt[2]  = '{2'd2, 8'd0,   8'd0,   8'd0};
    vt[3]  = '{2'd3, 8'd250, 8'd0,   8'd249};
    vt[4]  = '{2'd0, 8'd0,   8'd0,   8'd0};
    vt[5]  = '{2'd0, 8'd1,   8'd250, 8'd0};
    vt[6]  = '{2'd1, 8'd5,   8'd5,   8'd0};
    vt[7]  = '{2'd1, 8'd3,   8'd7,   8'd247};
    vt[8]  = '{2'd2, 8'd0,   8'd1,   8'd250};
    vt[9]  = '{2'd3, 8'd125, 8'd0,   8'd250};
    vt[10] = '{2'd3, 8'd126, 8'd0,   8'd1};
    vt[11] = '{2'd0, 8'd100, 8'd50,  8'd150};
    rst = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_a = 8'd0; in_b = 8'd0; in_tag = 8'd0; out_ready = 1'b1;
    d_in_valid = 1'b0; d_in_op = 2'd0; d_in_a = 32'd0; d_in_b = 32'd0; d_in_tag = 8'd0; d_out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_res", 32'(out_res), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_def_valid", 32'(d_out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_op = vt[i].op; in_a = vt[i].a; in_b = vt[i].b; in_tag = 8'(i);
      chk("tbl_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("tbl_lat1_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("tbl_lat2_valid", 32'(out_valid), 32'd1);
      chk("tbl_res", 32'(out_res), 32'(vt[i].exp));
      chk("tbl_tag", 32'(out_tag), 32'(i));
    end

    @(posedge clk); #1;
    d_in_valid = 1'b1; d_in_op = 2'd0; d_in_a = DP - 32'd1; d_in_b = DP - 32'd1; d_in_tag = 8'hA5;
    chk("def_ready", 32'(d_in_ready), 32'd1);
    @(posedge clk); #1;
    d_in_valid = 1'b1; d_in_op = 2'd1; d_in_a = 32'd0; d_in_b = 32'd1; d_in_tag = 8'h5A;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    chk("def_add_valid", 32'(d_out_valid), 32'd1);
    chk("def_add_res", d_out_res, DP - 32'd2);
    chk("def_add_tag", 32'(d_out_tag), 32'hA5);
    @(posedge clk); #1;
    chk("def_sub_res", d_out_res, DP - 32'd1);
    chk("def_sub_tag", 32'(d_out_tag), 32'h5A);
    @(posedge clk); #1;
    chk("def_idle", 32'(d_busy), 32'd0);

    out_ready = 1'b1;
    n0 = n_out;
    for (int i = 0; i < 100; i++) begin
      drive_rand(8'(i));
      if (i >= 2) chk("b2b_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("b2b_count", 32'(n_out - n0), 32'd100);
    chk("b2b_q_empty", 32'(exp_q.size()), 32'd0);

    tag_n = 8'd0;
    repeat (400) begin
      @(negedge clk);
      fired = in_valid && in_ready;
      @(posedge clk); #1;
      if (fired) tag_n++;
      if (fired || !in_valid) begin
        drive_rand(tag_n);
        in_valid = ($urandom_range(0, 1) == 1);
      end
      out_ready = ($urandom_range(0, 9) < 3);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 20 && busy; k++) begin
      @(posedge clk); #1;
    end
    chk("rand_drain_busy", 32'(busy), 32'd0);
    chk("rand_q_empty", 32'(exp_q.size()), 32'd0);

    @(posedge clk); #1;
    out_ready = 1'b0;
    drive_rand(8'd200);
    @(posedge clk); #1;
    drive_rand(8'd201);
    @(posedge clk); #1;
    drive_rand(8'd202);
    repeat (5) begin
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1 chk("drain_accept_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive_rand(8'(203 + i));
      chk("nobubble_valid", 32'(out_valid), 32'd1);
      chk("nobubble_ready", 32'(in_ready), 32'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("full_q_empty", 32'(exp_q.size()), 32'd0);

    drive_rand(8'd50);
    @(posedge clk); #1;
    drive_rand(8'd51);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_res", 32'(out_res), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_rel_ready", 32'(in_ready), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_stale", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b1; in_op = 2'd0; in_a = 8'd200; in_b = 8'd100; in_tag = 8'd77;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_res", 32'(out_res), 32'd49);
    chk("post_rst_tag", 32'(out_tag), 32'd77);
    repeat (2) @(posedge clk);
    #1 chk("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
